// File: rtl/picomips_pkg.sv
// Shared picoMIPS definitions: ALU/controller function codes, the fxdiv
// state encoding and the fixed-point format constants.
package picomips_pkg;

   localparam int FXDIV_N   = 8;
   localparam int FRAC_BITS = FXDIV_N - 1;

   // RDIV drives the fractional divider that sits beside the ALU
   typedef enum logic [2:0] {
      ADD, ADDI, SUB, SUBI, MUL, MULI, RDIV
   } func_t;

   typedef enum logic [1:0] {
      IDLE, CALC, FIN
   } fxdiv_state_t;

   // largest positive Q1.(n-1) code
   function automatic int qmax(input int n);
      return (1 << (n - 1)) - 1;
   endfunction

   // most negative Q1.(n-1) code
   function automatic int qmin(input int n);
      return -(1 << (n - 1));
   endfunction

   localparam int QMAX = qmax(FXDIV_N);
   localparam int QMIN = qmin(FXDIV_N);

endpackage

// File: rtl/fxdiv_if.sv
// Controller <-> fxdiv start/busy/done handshake with operands and result.
interface fxdiv_if #(parameter int N = 8);
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] q;
   logic         ovf;
   logic         dz;

   modport master (output start, a, b, input busy, done, q, ovf, dz);
   modport slave  (input start, a, b, output busy, done, q, ovf, dz);
endinterface

// File: rtl/fxdiv_step.sv
// One restoring-division step: trial subtract of the divisor magnitude from
// the shifted partial remainder.
module fxdiv_step #(parameter int N = 8) (
   input  logic [N:0]   rem_in,
   input  logic [N-1:0] div,
   output logic [N-1:0] rem_out,
   output logic         qbit
);
   logic [N-1:0] diff;

   // after a successful subtract the remainder is below |b|, so N bits hold it
   always_comb begin
      qbit    = (rem_in >= {1'b0, div});
      diff    = rem_in[N-1:0] - div;
      rem_out = qbit ? diff : rem_in[N-1:0];
   end
endmodule

// File: rtl/fxdiv.sv
// Sequential signed Q1.(n-1) divider, one quotient bit per clock, saturating.
// Optional build macro: FXDIV_ROUND_EN (round half away from zero instead of
// truncating toward zero).
//
// state | meaning
// IDLE  | waiting for start, operands captured on start
// CALC  | shift-subtract iterations, N_IT cycles
// FIN   | sign, round/saturate, register result, pulse done
module fxdiv
   import picomips_pkg::*;
#(
   parameter int N = FXDIV_N
) (
   input  logic   clk,
   input  logic   nReset,
   fxdiv_if.slave bus
);
   localparam int F   = N - 1;
   localparam int NIT = N + F;
   localparam int DW  = 2 * N - 1;
   localparam int MW  = NIT + 1;
   localparam int CW  = $clog2(NIT + 1);

   localparam logic [N-1:0]  Q_MAX   = N'(qmax(N));
   localparam logic [N-1:0]  Q_MIN   = N'(qmin(N));
   localparam logic [MW-1:0] MAG_POS = MW'(qmax(N));
   localparam logic [MW-1:0] MAG_NEG = MW'(-qmin(N));

   fxdiv_state_t   state, state_nxt;
   logic           sign, a_neg;
   logic [N-1:0]   mag_b;
   logic [DW-1:0]  dvd;
   logic [N-1:0]   rem;
   logic [NIT-1:0] quo;
   logic [CW-1:0]  cnt;
   logic           busy_r, done_r, ovf_r, dz_r;
   logic [N-1:0]   q_r;

   logic [N-1:0]   a_abs, b_abs;
   logic [N:0]     rem_sh;
   logic [N-1:0]   rem_nxt;
   logic           qbit;
   logic [MW-1:0]  mag;
   logic [N-1:0]   q_fin;
   logic           ovf_fin, dz_fin;

   // magnitudes as unsigned n-bit values; the most negative code maps to 2^(n-1)
   assign a_abs  = bus.a[N-1] ? (~bus.a + 1'b1) : bus.a;
   assign b_abs  = bus.b[N-1] ? (~bus.b + 1'b1) : bus.b;
   assign rem_sh = {rem, dvd[DW-1]};

   fxdiv_step #(.N(N)) u_step (
      .rem_in  (rem_sh),
      .div     (mag_b),
      .rem_out (rem_nxt),
      .qbit    (qbit)
   );

   // state register
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) state <= IDLE;
      else         state <= state_nxt;
   end

   // next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = CALC;
         CALC:    if (cnt == CW'(1)) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // final magnitude, sign application, saturation and divide-by-zero override
   always_comb begin
      mag = {1'b0, quo};
`ifdef FXDIV_ROUND_EN
      if ({rem, 1'b0} >= {1'b0, mag_b}) mag = mag + 1'b1;
`endif
      q_fin   = mag[N-1:0];
      ovf_fin = 1'b0;
      dz_fin  = 1'b0;
      if (mag_b == '0) begin
         dz_fin = 1'b1;
         q_fin  = a_neg ? Q_MIN : Q_MAX;
      end else if (!sign) begin
         if (mag > MAG_POS) begin
            q_fin   = Q_MAX;
            ovf_fin = 1'b1;
         end
      end else if (mag > MAG_NEG) begin
         q_fin   = Q_MIN;
         ovf_fin = 1'b1;
      end else begin
         q_fin = ~mag[N-1:0] + 1'b1;
      end
   end

   // datapath and registered outputs
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         sign   <= 1'b0;
         a_neg  <= 1'b0;
         mag_b  <= '0;
         dvd    <= '0;
         rem    <= '0;
         quo    <= '0;
         cnt    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         q_r    <= '0;
         ovf_r  <= 1'b0;
         dz_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               sign   <= bus.a[N-1] ^ bus.b[N-1];
               a_neg  <= bus.a[N-1];
               mag_b  <= b_abs;
               dvd    <= {a_abs, {F{1'b0}}};
               rem    <= '0;
               quo    <= '0;
               cnt    <= CW'(NIT);
               busy_r <= 1'b1;
            end
            CALC: begin
               dvd <= {dvd[DW-2:0], 1'b0};
               rem <= rem_nxt;
               quo <= {quo[NIT-2:0], qbit};
               cnt <= cnt - 1'b1;
            end
            FIN: begin
               q_r    <= q_fin;
               ovf_r  <= ovf_fin;
               dz_r   <= dz_fin;
               done_r <= 1'b1;
               busy_r <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.q    = q_r;
   assign bus.ovf  = ovf_r;
   assign bus.dz   = dz_r;
endmodule

// File: tb/tb_fxdiv.sv
// Self-checking bench for fxdiv: expected results are queued at start and
// compared when done pulses.
module tb_fxdiv;
   logic clk = 1'b0;
   logic nReset;

   fxdiv_if #(.N(8)) bus ();

   fxdiv dut (
      .clk    (clk),
      .nReset (nReset),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] q;
      logic       ovf;
      logic       dz;
      int         k;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // arithmetic reference: |a|*2^7 / |b| with integer division
   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int k);
      int   av, bv, num, den, mag, r;
      exp_t e;
      av    = int'($signed(a));
      bv    = int'($signed(b));
      e.k   = k;
      e.ovf = 1'b0;
      e.dz  = 1'b0;
      if (bv == 0) begin
         e.dz = 1'b1;
         e.q  = (av >= 0) ? 8'h7F : 8'h80;
         return e;
      end
      num = ((av < 0) ? -av : av) * 128;
      den = (bv < 0) ? -bv : bv;
      mag = num / den;
      r   = num % den;
`ifdef FXDIV_ROUND_EN
      if (2 * r >= den) mag++;
`endif
      if ((av < 0) != (bv < 0)) begin
         if (mag > 128) begin
            e.q   = 8'h80;
            e.ovf = 1'b1;
         end else begin
            e.q = 8'(-mag);
         end
      end else if (mag > 127) begin
         e.q   = 8'h7F;
         e.ovf = 1'b1;
      end else begin
         e.q = 8'(mag);
      end
      return e;
   endfunction

   // result monitor
   always @(negedge clk) begin
      if (nReset && bus.done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("q",       int'(bus.q),   int'(mon_e.q));
            chk("ovf",     int'(bus.ovf), int'(mon_e.ovf));
            chk("dz",      int'(bus.dz),  int'(mon_e.dz));
            chk("latency", cyc - mon_e.k, 16);
         end
      end
   end

   // call at a negedge: start is sampled at the next posedge
   task automatic launch(input logic [7:0] a, input logic [7:0] b);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      sb.push_back(model(a, b, cyc + 1));
   endtask

   // returns at the negedge where done is seen
   task automatic wait_done(input bit inject);
      int bc;
      bit seen;
      bc   = 0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 0) bus.start = 1'b0;
         if (inject && i == 4) begin
            bus.start = 1'b1;
            bus.a     = 8'h7F;
            bus.b     = 8'h01;
         end
         if (inject && i == 5) bus.start = 1'b0;
         if (bus.busy) bc++;
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      chk("done_seen", int'(seen), 1);
      chk("busy_cycles", bc, 16);
   endtask

   task automatic run(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      launch(a, b);
      wait_done(1'b0);
      @(negedge clk);
      chk("done_pulse", int'(bus.done), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] ra, rb;
      nReset    = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_q",    int'(bus.q),    0);
      chk("rst_ovf",  int'(bus.ovf),  0);
      chk("rst_dz",   int'(bus.dz),   0);
      nReset = 1'b1;

      run(8'h20, 8'h40);
      run(8'hE0, 8'h40);
      run(8'h01, 8'h03);
      run(8'h40, 8'h20);
      run(8'h80, 8'h80);
      run(8'h80, 8'h7F);
      run(8'h10, 8'h00);
      run(8'hF0, 8'h00);
      run(8'h00, 8'h40);
      run(8'h00, 8'hC0);
      run(8'h7F, 8'h81);
      for (int i = 0; i < 8; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         run(ra, rb);
      end

      // start while busy must be ignored
      @(negedge clk);
      launch(8'h20, 8'h40);
      wait_done(1'b1);
      @(negedge clk);
      chk("ignore_no_extra", int'(bus.busy), 0);

      // back-to-back: next start issued in the done cycle
      launch(8'hE0, 8'h40);
      wait_done(1'b0);
      launch(8'h01, 8'h03);
      wait_done(1'b0);

      // asynchronous reset mid-calculation
      @(negedge clk);
      launch(8'h30, 8'h50);
      repeat (8) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      #2 nReset = 1'b0;
      #1;
      sb.delete();
      chk("arst_busy", int'(bus.busy), 0);
      chk("arst_done", int'(bus.done), 0);
      chk("arst_q",    int'(bus.q),    0);
      chk("arst_ovf",  int'(bus.ovf),  0);
      chk("arst_dz",   int'(bus.dz),   0);
      repeat (3) @(negedge clk);
      nReset = 1'b1;
      repeat (20) @(negedge clk);
      chk("arst_no_done", int'(bus.done), 0);
      run(8'h20, 8'h40);

      @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/fxdiv.md
# fxdiv

Sequential signed fixed-point divider for the picoMIPS datapath, providing the inverse of the ALU's fractional multiply. It divides two n-bit two's-complement Q1.(n-1) operands, producing a saturated Q1.(n-1) quotient through a restoring shift-subtract iteration, one quotient bit per clock. It sits beside the ALU and is driven by the controller through a start/busy/done handshake. The controller stalls the pipeline while busy is high.

## Interface
- n, 8, operand and result width; fraction bits F = n-1
- clk  input  1  system clock, rising-edge
- nReset  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- a  input  n  dividend, signed Q1.(n-1), captured with start
- b  input  n  divisor, signed Q1.(n-1), captured with start
- busy  output  1  division in progress
- done  output  1  one-cycle pulse, q and flags valid
- q  output  n  signed quotient, held until next completion
- ovf  output  1  quotient saturated; held with q
- dz  output  1  divisor was zero; held with q

## Operation
- States: IDLE, CALC, FIN (state typedef enum).
- IDLE + start=1:
  - Capture sign = a[n-1]^b[n-1].
  - Capture |a| and |b| as n-bit unsigned; |0x80| = 128.
  - Dividend = |a| << F, which is 2n-1 bits.
  - Clear remainder and quotient; load iteration counter with N_IT = n+F.
  - Move to CALC.
- CALC, each cycle:
  - rem = {rem, next dividend MSB}.
  - If rem >= |b|, subtract |b| and shift in quotient bit 1; otherwise shift in 0.
  - Decrement the counter. At counter 1, move to FIN.
- FIN:
  - Apply sign to the magnitude.
  - Saturate: positive magnitude > 2^(n-1)-1 gives q = 0x7F and ovf = 1; negative magnitude > 2^(n-1) gives q = 0x80 and ovf = 1.
  - Default rounding is truncation toward zero.
  - Register q, ovf and dz; pulse done; return to IDLE.
- b == 0:
  - Latency is unchanged and the datapath runs normally.
  - FIN forces q = 0x7F if a >= 0, else 0x80; dz = 1 and ovf = 0.
- a == 0 with b != 0: q = 0, no flags.
- start while busy is ignored and the operands are not recaptured.
- start in the cycle done is high is accepted, because the block is already in IDLE.

## Timing
- Reset values: state IDLE; busy, done, ovf, dz = 0; q = 0; all internal registers zero.
- Reset is asynchronous at any point, including mid-CALC. It aborts the division immediately, and no done follows.
- Handshake timeline, with start sampled at edge k:
  - busy = 1 from after edge k through the cycle ending at edge k+N_IT+1.
  - CALC occupies edges k+1 .. k+N_IT.
  - FIN occurs at edge k+N_IT+1, which registers q and flags, sets done = 1 and busy = 0.
  - done falls at the following edge.
- Total latency: N_IT+1 edges from the start edge to done, which is 16 for n = 8.
- q, ovf and dz change only at the FIN edge or on reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- FXDIV_ROUND_EN defined: round to nearest, half away from zero.
  - FIN increments the magnitude when 2*rem >= |b|, then applies saturation.
  - An increment that crosses the limit sets ovf.
- Undefined: truncation toward zero, and the rounding compare is not synthesised.
- Latency is identical in both builds.

## Structure
- Shared package picomips_pkg holds:
  - the fxdiv state enum;
  - constant FRAC_BITS;
  - saturation constants QMAX/QMIN, as functions of n;
  - a new func code RDIV, added alongside the existing ALU codes for the controller.
- One sub-module, fxdiv_step: a combinational trial subtract taking rem and |b|, returning the next rem and the quotient bit. It is instantiated once in CALC.

## Test plan
- a=0x20, b=0x40 (0.25/0.5) -> done after 16 edges; q=0x40, ovf=0, dz=0; busy high for exactly 16 cycles.
- a=0xE0, b=0x40 -> q=0xC0. a=0x01, b=0x03 -> q=0x2A without FXDIV_ROUND_EN, 0x2B with it.
- a=0x40, b=0x20 (2.0) -> q=0x7F, ovf=1. a=0x80, b=0x80 -> q=0x7F, ovf=1. a=0x80, b=0x7F -> q=0x80, ovf=1.
- b=0x00: a=0x10 -> q=0x7F, dz=1; a=0xF0 -> q=0x80, dz=1; same 16-edge latency.
- start pulsed with new operands at edge k+5 while busy -> ignored; result is that of the first operands.
- start re-asserted in the done cycle -> accepted back-to-back.
- nReset low at edge k+8 -> all outputs 0 asynchronously; no done; next start completes normally.
